rs_alu_station: RTL and testbench
=================================

Name: rs_alu_station

Overview:
- Reservation-station bank for one functional-unit type in the Tomasulo core.
- Sits between the issue stage/register file and the FU. It receives operand values or producer tags read from the register file and RAT at issue, and returns its allocated tag as the RAT rename tag.
- Snoops the CDB for missing operands, dispatches ready entries to the FU with a valid/ready handshake, and frees each entry when its own result is broadcast.

Parameters:
- NUM_ENTRIES, 4, number of station entries; legal range 1..31.
- FU_TYPE, 3'd1, value placed in tag bits [7:5].
- OP_W, 4, opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- is_valid  in  1  issue request this cycle
- is_ready  out  1  at least one FREE entry exists
- is_op  in  OP_W  operation to perform
- is_qj  in  8  producer tag for operand A; 0 = value valid
- is_vj  in  32  operand A value; used only when is_qj==0
- is_qk  in  8  producer tag for operand B; 0 = value valid
- is_vk  in  32  operand B value; used only when is_qk==0
- is_rs_num  out  8  tag the next issue will receive, {FU_TYPE, index}; drives the RAT write tag
- cdb_rs_num  in  8  CDB broadcast tag; 0 = no broadcast
- cdb_data  in  32  CDB broadcast value
- fu_valid  out  1  a dispatch candidate is presented
- fu_ready  in  1  FU accepts the candidate
- fu_op  out  OP_W  opcode of the candidate
- fu_a  out  32  operand A of the candidate
- fu_b  out  32  operand B of the candidate
- fu_rs_num  out  8  tag of the candidate; the FU returns it on the CDB

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - All entries go FREE, with operand, tag and op fields cleared to 0.
  - is_ready=1 and is_rs_num={FU_TYPE,5'd1}.
  - fu_valid=0 and all fu_* data outputs are 0.
  - Asserting rst mid-operation discards every entry, including entries in EXEC.
- Entry i (1..NUM_ENTRIES) has tag {FU_TYPE, i[4:0]}. Tag 0 is never allocated.
- Per-entry state: FREE, WAIT (at least one operand tag nonzero), READY (both tags 0), EXEC (dispatched, awaiting its own CDB broadcast).
- Allocation:
  - is_rs_num is combinational and gives the lowest-index FREE entry.
  - When no entry is FREE: is_ready=0 and is_rs_num=0.
  - Issue happens at the edge where is_valid && is_ready; the entry latches op, qj, vj, qk, vk.
  - is_valid while is_ready=0 is ignored, with no state change.
- Issue-cycle CDB bypass:
  - If cdb_rs_num!=0 and equals is_qj, the entry stores vj=cdb_data and qj=0. The same rule applies to qk.
  - The entry enters READY directly if both tags resolve; otherwise it enters WAIT.
- CDB capture in WAIT:
  - Each edge, every WAIT entry with qj==cdb_rs_num (nonzero) latches vj=cdb_data and qj=0. The same rule applies to qk; both may resolve in the same cycle.
  - The entry moves to READY at that edge.
  - Dispatch eligibility starts the following cycle.
- Dispatch:
  - fu_valid=1 when any entry is READY. fu_* are combinational from the lowest-index READY entry.
  - fu_* outputs are 0 when fu_valid=0.
  - On an edge with fu_valid && fu_ready, the presented entry moves to EXEC.
  - While fu_ready=0, the candidate stays stable unless a lower-index entry becomes READY.
- Release:
  - An EXEC entry whose tag equals cdb_rs_num goes FREE at that edge.
  - It is reallocatable in the next cycle, not the same one; is_ready depends on registered state only.
  - The tag therefore stays unique for as long as any RAT slot or station can reference it.
- Simultaneous events in one cycle must all take effect independently:
  - issue into entry j
  - CDB release of entry i
  - CDB capture in other entries
  - dispatch of entry k
- CDB with a tag matching an entry not in EXEC: no state change for that entry's own state; operand capture still applies.
- Width: all values are 32-bit pass-through with no arithmetic. Index compare uses the full 8-bit tag.

Test Plan:
- Reset, then issue op=3, qj=0, vj=5, qk=0, vk=7 -> is_rs_num was 8'h21. Next cycle: fu_valid=1, fu_a=5, fu_b=7, fu_rs_num=8'h21. With fu_ready=1, the entry goes to EXEC.
- Issue with qj=8'h42, vk=9 -> entry WAIT, fu_valid=0. Then cdb_rs_num=8'h42, cdb_data=100 -> next cycle fu_valid=1, fu_a=100, fu_b=9.
- Issue qj=8'h42 in the same cycle as cdb_rs_num=8'h42, cdb_data=77 -> entry READY immediately; next cycle fu_a=77.
- Fill all 4 entries -> is_ready=0, is_rs_num=0, and a further is_valid is ignored. Broadcast 8'h22 while entry 2 is in EXEC -> is_ready=1 and is_rs_num=8'h22 next cycle.
- Entries 1 and 3 READY with fu_ready=0 for 3 cycles -> fu_rs_num held at 8'h21. Raise fu_ready -> entry 1 dispatched, then 8'h23 presented.
- Assert rst while entries are in WAIT/EXEC -> all outputs at reset values immediately; a later CDB broadcast of a stale tag causes no change.

Source files
------------

// File: rtl/rs_alu_station_if.sv
// Issue, CDB and FU-dispatch signal bundle for one ALU reservation-station bank.
// master = issue stage / CDB / FU side, slave = the station itself.
interface rs_alu_station_if #(
    parameter int OP_W = 4
);
    logic            is_valid;
    logic            is_ready;
    logic [OP_W-1:0] is_op;
    logic [7:0]      is_qj;
    logic [31:0]     is_vj;
    logic [7:0]      is_qk;
    logic [31:0]     is_vk;
    logic [7:0]      is_rs_num;

    logic [7:0]      cdb_rs_num;
    logic [31:0]     cdb_data;

    logic            fu_valid;
    logic            fu_ready;
    logic [OP_W-1:0] fu_op;
    logic [31:0]     fu_a;
    logic [31:0]     fu_b;
    logic [7:0]      fu_rs_num;

    modport master (
        output is_valid, is_op, is_qj, is_vj, is_qk, is_vk,
        output cdb_rs_num, cdb_data, fu_ready,
        input  is_ready, is_rs_num, fu_valid, fu_op, fu_a, fu_b, fu_rs_num
    );

    modport slave (
        input  is_valid, is_op, is_qj, is_vj, is_qk, is_vk,
        input  cdb_rs_num, cdb_data, fu_ready,
        output is_ready, is_rs_num, fu_valid, fu_op, fu_a, fu_b, fu_rs_num
    );
endinterface

// File: rtl/rs_alu_station.sv
// Tomasulo reservation-station bank: issue with CDB bypass, CDB operand capture,
// lowest-index dispatch to the FU, and release on the entry's own CDB broadcast.
//
// state   | meaning
// FREE    | entry unallocated, its tag may be handed out at issue
// WAIT    | allocated, at least one operand tag still outstanding
// READY   | both operands present, eligible for dispatch
// EXEC    | handed to the FU, waiting for its own tag on the CDB
module rs_alu_station #(
    parameter int         NUM_ENTRIES = 4,
    parameter logic [2:0] FU_TYPE     = 3'd1,
    parameter int         OP_W        = 4
) (
    input  logic           clk,
    input  logic           rst,
    rs_alu_station_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } ent_state_t;

    ent_state_t      r_state [1:NUM_ENTRIES];
    logic [OP_W-1:0] r_op    [1:NUM_ENTRIES];
    logic [7:0]      r_qj    [1:NUM_ENTRIES];
    logic [31:0]     r_vj    [1:NUM_ENTRIES];
    logic [7:0]      r_qk    [1:NUM_ENTRIES];
    logic [31:0]     r_vk    [1:NUM_ENTRIES];

    ent_state_t      w_state_nxt [1:NUM_ENTRIES];
    logic [OP_W-1:0] w_op_nxt    [1:NUM_ENTRIES];
    logic [7:0]      w_qj_nxt    [1:NUM_ENTRIES];
    logic [31:0]     w_vj_nxt    [1:NUM_ENTRIES];
    logic [7:0]      w_qk_nxt    [1:NUM_ENTRIES];
    logic [31:0]     w_vk_nxt    [1:NUM_ENTRIES];

    logic            w_any_free;
    logic [4:0]      w_free_idx;
    logic            w_any_ready;
    logic [4:0]      w_rdy_idx;
    logic [OP_W-1:0] w_fu_op;
    logic [31:0]     w_fu_a;
    logic [31:0]     w_fu_b;
    logic            w_issue;
    logic            w_dispatch;
    logic            w_cdb_live;
    logic            w_byp_j;
    logic            w_byp_k;

    // Lowest-index FREE and READY entries: scan high to low so the lowest match wins.
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = 5'd0;
        w_any_ready = 1'b0;
        w_rdy_idx   = 5'd0;
        w_fu_op     = '0;
        w_fu_a      = 32'd0;
        w_fu_b      = 32'd0;
        for (int i = NUM_ENTRIES; i >= 1; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = 5'(i);
            end
            if (r_state[i] == ST_READY) begin
                w_any_ready = 1'b1;
                w_rdy_idx   = 5'(i);
                w_fu_op     = r_op[i];
                w_fu_a      = r_vj[i];
                w_fu_b      = r_vk[i];
            end
        end
    end

    assign w_issue    = bus.is_valid && w_any_free;
    assign w_dispatch = w_any_ready && bus.fu_ready;
    assign w_cdb_live = (bus.cdb_rs_num != 8'd0);
    assign w_byp_j    = w_cdb_live && (bus.is_qj == bus.cdb_rs_num);
    assign w_byp_k    = w_cdb_live && (bus.is_qk == bus.cdb_rs_num);

    assign bus.is_ready  = w_any_free;
    assign bus.is_rs_num = w_any_free ? {FU_TYPE, w_free_idx} : 8'd0;
    assign bus.fu_valid  = w_any_ready;
    assign bus.fu_op     = w_fu_op;
    assign bus.fu_a      = w_fu_a;
    assign bus.fu_b      = w_fu_b;
    assign bus.fu_rs_num = w_any_ready ? {FU_TYPE, w_rdy_idx} : 8'd0;

    always_comb begin
        for (int i = 1; i <= NUM_ENTRIES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_op_nxt[i]    = r_op[i];
            w_qj_nxt[i]    = r_qj[i];
            w_vj_nxt[i]    = r_vj[i];
            w_qk_nxt[i]    = r_qk[i];
            w_vk_nxt[i]    = r_vk[i];

            case (r_state[i])
                ST_FREE: begin
                    if (w_issue && (w_free_idx == 5'(i))) begin
                        w_op_nxt[i] = bus.is_op;
                        // A producer broadcasting in the issue cycle would otherwise be missed.
                        if (w_byp_j) begin
                            w_qj_nxt[i] = 8'd0;
                            w_vj_nxt[i] = bus.cdb_data;
                        end else begin
                            w_qj_nxt[i] = bus.is_qj;
                            w_vj_nxt[i] = bus.is_vj;
                        end
                        if (w_byp_k) begin
                            w_qk_nxt[i] = 8'd0;
                            w_vk_nxt[i] = bus.cdb_data;
                        end else begin
                            w_qk_nxt[i] = bus.is_qk;
                            w_vk_nxt[i] = bus.is_vk;
                        end
                        w_state_nxt[i] = ((w_qj_nxt[i] == 8'd0) && (w_qk_nxt[i] == 8'd0))
                                         ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_cdb_live && (r_qj[i] == bus.cdb_rs_num)) begin
                        w_qj_nxt[i] = 8'd0;
                        w_vj_nxt[i] = bus.cdb_data;
                    end
                    if (w_cdb_live && (r_qk[i] == bus.cdb_rs_num)) begin
                        w_qk_nxt[i] = 8'd0;
                        w_vk_nxt[i] = bus.cdb_data;
                    end
                    if ((w_qj_nxt[i] == 8'd0) && (w_qk_nxt[i] == 8'd0)) begin
                        w_state_nxt[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_dispatch && (w_rdy_idx == 5'(i))) begin
                        w_state_nxt[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Freed here; the scan above only sees it FREE from the next cycle on.
                    if (bus.cdb_rs_num == {FU_TYPE, 5'(i)}) begin
                        w_state_nxt[i] = ST_FREE;
                    end
                end
                default: w_state_nxt[i] = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= NUM_ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
                r_op[i]    <= '0;
                r_qj[i]    <= 8'd0;
                r_vj[i]    <= 32'd0;
                r_qk[i]    <= 8'd0;
                r_vk[i]    <= 32'd0;
            end
        end else begin
            for (int i = 1; i <= NUM_ENTRIES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_op[i]    <= w_op_nxt[i];
                r_qj[i]    <= w_qj_nxt[i];
                r_vj[i]    <= w_vj_nxt[i];
                r_qk[i]    <= w_qk_nxt[i];
                r_vk[i]    <= w_vk_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios plus random traffic, each cycle
// checked against a behavioural model of the station's slots.
module tb_rs_alu_station;
    localparam int         N  = 4;
    localparam logic [2:0] FT = 3'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_alu_station_if #(.OP_W(4)) bus ();

    rs_alu_station #(.NUM_ENTRIES(N), .FU_TYPE(FT), .OP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a slot is in use or not, and once in use it has either been sent to the FU or not.
    bit          m_used [1:N];
    bit          m_sent [1:N];
    logic [3:0]  m_op   [1:N];
    logic [7:0]  m_qj   [1:N];
    logic [31:0] m_vj   [1:N];
    logic [7:0]  m_qk   [1:N];
    logic [31:0] m_vk   [1:N];

    logic [7:0] pool [6] = '{8'h41, 8'h42, 8'h43, 8'h21, 8'h23, 8'h24};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] tag_of(input int i);
        return {FT, 5'(i)};
    endfunction

    function automatic int first_free();
        for (int i = 1; i <= N; i++) if (!m_used[i]) return i;
        return 0;
    endfunction

    function automatic int first_ready();
        for (int i = 1; i <= N; i++)
            if (m_used[i] && !m_sent[i] && m_qj[i] == 8'd0 && m_qk[i] == 8'd0) return i;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= N; i++) begin
            m_used[i] = 0; m_sent[i] = 0; m_op[i] = 0;
            m_qj[i] = 0; m_vj[i] = 0; m_qk[i] = 0; m_vk[i] = 0;
        end
    endtask

    task automatic drive_idle();
        bus.is_valid = 0; bus.is_op = 0; bus.is_qj = 0; bus.is_vj = 0;
        bus.is_qk = 0; bus.is_vk = 0; bus.cdb_rs_num = 0; bus.cdb_data = 0;
        bus.fu_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check_eq("rst_is_ready", 32'(bus.is_ready), 32'd1);
        check_eq("rst_is_rs_num", 32'(bus.is_rs_num), 32'h21);
        check_eq("rst_fu_valid", 32'(bus.fu_valid), 32'd0);
        check_eq("rst_fu_op", 32'(bus.fu_op), 32'd0);
        check_eq("rst_fu_a", bus.fu_a, 32'd0);
        check_eq("rst_fu_b", bus.fu_b, 32'd0);
        check_eq("rst_fu_rs_num", 32'(bus.fu_rs_num), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance the model
    // to what the coming clock edge should produce.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [7:0] qj,
                         input logic [31:0] vj, input logic [7:0] qk, input logic [31:0] vk,
                         input logic [7:0] cdb, input logic [31:0] data, input logic frdy);
        int fi, ri;
        bit          o_used [1:N];
        bit          o_sent [1:N];
        logic [7:0]  o_qj   [1:N];
        logic [7:0]  o_qk   [1:N];
        @(negedge clk);
        bus.is_valid = v; bus.is_op = op; bus.is_qj = qj; bus.is_vj = vj;
        bus.is_qk = qk; bus.is_vk = vk; bus.cdb_rs_num = cdb; bus.cdb_data = data;
        bus.fu_ready = frdy;
        #1;
        fi = first_free();
        ri = first_ready();
        check_eq("is_ready", 32'(bus.is_ready), 32'(fi != 0));
        check_eq("is_rs_num", 32'(bus.is_rs_num), 32'((fi != 0) ? tag_of(fi) : 8'd0));
        check_eq("fu_valid", 32'(bus.fu_valid), 32'(ri != 0));
        check_eq("fu_op", 32'(bus.fu_op), 32'((ri != 0) ? m_op[ri] : 4'd0));
        check_eq("fu_a", bus.fu_a, (ri != 0) ? m_vj[ri] : 32'd0);
        check_eq("fu_b", bus.fu_b, (ri != 0) ? m_vk[ri] : 32'd0);
        check_eq("fu_rs_num", 32'(bus.fu_rs_num), 32'((ri != 0) ? tag_of(ri) : 8'd0));

        o_used = m_used; o_sent = m_sent; o_qj = m_qj; o_qk = m_qk;
        for (int i = 1; i <= N; i++) begin
            if (o_used[i] && o_sent[i] && cdb == tag_of(i)) begin
                m_used[i] = 0;
                m_sent[i] = 0;
            end
            if (o_used[i] && cdb != 8'd0 && o_qj[i] == cdb) begin
                m_qj[i] = 0; m_vj[i] = data;
            end
            if (o_used[i] && cdb != 8'd0 && o_qk[i] == cdb) begin
                m_qk[i] = 0; m_vk[i] = data;
            end
        end
        if (ri != 0 && frdy) m_sent[ri] = 1;
        if (v && fi != 0) begin
            m_used[fi] = 1; m_sent[fi] = 0; m_op[fi] = op;
            m_qj[fi] = qj; m_vj[fi] = vj; m_qk[fi] = qk; m_vk[fi] = vk;
            if (cdb != 8'd0 && qj == cdb) begin m_qj[fi] = 0; m_vj[fi] = data; end
            if (cdb != 8'd0 && qk == cdb) begin m_qk[fi] = 0; m_vk[fi] = data; end
        end
    endtask

    task automatic idle(input logic [7:0] cdb, input logic [31:0] data, input logic frdy);
        cycle(1'b0, 4'd0, 8'd0, 32'd0, 8'd0, 32'd0, cdb, data, frdy);
    endtask

    task automatic rand_cycle();
        logic [7:0] qj, qk, cdb;
        int ex[$];
        int r;
        for (int i = 1; i <= N; i++) if (m_used[i] && m_sent[i]) ex.push_back(i);
        qj = ($urandom % 2 == 0) ? 8'd0 : pool[$urandom_range(0, 5)];
        qk = ($urandom % 2 == 0) ? 8'd0 : pool[$urandom_range(0, 5)];
        r  = int'($urandom % 10);
        if (r < 4 && ex.size() > 0) cdb = tag_of(ex[$urandom_range(0, ex.size() - 1)]);
        else if (r < 7)             cdb = pool[$urandom_range(0, 5)];
        else                        cdb = 8'd0;
        cycle(($urandom % 3) != 0, 4'($urandom), qj, $urandom, qk, $urandom,
              cdb, $urandom, 1'($urandom % 2));
    endtask

    initial begin
        drive_idle();
        model_clear();
        do_reset();

        // Ready-at-issue entry, then dispatch.
        cycle(1, 4'd3, 8'h00, 32'd5, 8'h00, 32'd7, 8'h00, 32'd0, 0);
        check_eq("tp1_tag", 32'(bus.is_rs_num), 32'h21);
        idle(8'h00, 32'd0, 1);
        check_eq("tp1_fu_valid", 32'(bus.fu_valid), 32'd1);
        check_eq("tp1_fu_a", bus.fu_a, 32'd5);
        check_eq("tp1_fu_b", bus.fu_b, 32'd7);
        check_eq("tp1_fu_rs_num", 32'(bus.fu_rs_num), 32'h21);

        // WAIT then CDB capture.
        cycle(1, 4'd2, 8'h42, 32'd0, 8'h00, 32'd9, 8'h00, 32'd0, 0);
        idle(8'h42, 32'd100, 0);
        check_eq("tp2_wait_fu_valid", 32'(bus.fu_valid), 32'd0);
        idle(8'h00, 32'd0, 1);
        check_eq("tp2_fu_valid", 32'(bus.fu_valid), 32'd1);
        check_eq("tp2_fu_a", bus.fu_a, 32'd100);
        check_eq("tp2_fu_b", bus.fu_b, 32'd9);

        // Issue-cycle bypass.
        cycle(1, 4'd5, 8'h42, 32'd0, 8'h00, 32'd1, 8'h42, 32'd77, 0);
        idle(8'h00, 32'd0, 0);
        check_eq("tp3_fu_a", bus.fu_a, 32'd77);
        check_eq("tp3_fu_rs_num", 32'(bus.fu_rs_num), 32'h23);

        // Fill, ignored issue, release of entry 2.
        cycle(1, 4'd6, 8'h00, 32'd11, 8'h00, 32'd12, 8'h00, 32'd0, 0);
        cycle(1, 4'd7, 8'h00, 32'd1, 8'h00, 32'd2, 8'h00, 32'd0, 0);
        check_eq("tp4_full_ready", 32'(bus.is_ready), 32'd0);
        check_eq("tp4_full_tag", 32'(bus.is_rs_num), 32'd0);
        idle(8'h22, 32'd0, 0);
        check_eq("tp4_same_cycle_ready", 32'(bus.is_ready), 32'd0);
        idle(8'h00, 32'd0, 0);
        check_eq("tp4_freed_ready", 32'(bus.is_ready), 32'd1);
        check_eq("tp4_freed_tag", 32'(bus.is_rs_num), 32'h22);

        // Candidate held while the FU stalls.
        idle(8'h21, 32'd0, 0);
        cycle(1, 4'd8, 8'h00, 32'd21, 8'h00, 32'd22, 8'h00, 32'd0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(8'h00, 32'd0, 0);
            check_eq("tp5_hold", 32'(bus.fu_rs_num), 32'h21);
        end
        idle(8'h00, 32'd0, 1);
        check_eq("tp5_dispatch", 32'(bus.fu_rs_num), 32'h21);
        idle(8'h00, 32'd0, 0);
        check_eq("tp5_next", 32'(bus.fu_rs_num), 32'h23);

        // Mid-operation reset, then stale broadcasts.
        cycle(1, 4'd9, 8'h44, 32'd0, 8'h00, 32'd3, 8'h00, 32'd0, 0);
        do_reset();
        idle(8'h21, 32'd55, 0);
        idle(8'h44, 32'd66, 0);
        idle(8'h00, 32'd0, 0);
        check_eq("tp6_fu_valid", 32'(bus.fu_valid), 32'd0);
        check_eq("tp6_tag", 32'(bus.is_rs_num), 32'h21);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom % 400 == 0) do_reset();
            rand_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
